// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned icache requests (one or
// two instructions per group), follows branch predictions, keeps per-request
// metadata in an in-order FIFO and hands returned instructions to the
// instruction buffer. A flush redirects fetch and drops every response that
// was already in flight; a misaligned PC raises an ADEF fault and parks the
// unit until the next flush.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal fetching; misaligned PC raises ADEF once drained
// ST_STALL | ADEF delivered; no requests, no deliveries until flush
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h1c000000,
    parameter int          MAX_INFLIGHT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_addr_ok,
    input  logic        icache_data_ok,
    input  logic [63:0] icache_rdata,
    output logic [31:0] bp_pc,
    input  logic        bp_taken1,
    input  logic [31:0] bp_target1,
    input  logic        bp_taken2,
    input  logic [31:0] bp_target2,
    input  logic        ibuf_ready,
    output logic [1:0]  out_size,
    output logic [31:0] out_pc1,
    output logic [31:0] out_inst1,
    output logic        out_pred_taken1,
    output logic [31:0] out_pred_target1,
    output logic        out_have_exception1,
    output logic [5:0]  out_exception_type1,
    output logic [31:0] out_pc2,
    output logic [31:0] out_inst2,
    output logic        out_pred_taken2,
    output logic [31:0] out_pred_target2
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_INFLIGHT);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_INFLIGHT - 1);
    localparam logic [5:0]       EXC_ADEF = 6'h08;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      pc;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] cancel_cnt;
    logic [CNT_W-1:0] inflight_nxt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [31:0] meta_pc   [MAX_INFLIGHT];
    logic [1:0]  meta_size [MAX_INFLIGHT];
    logic        meta_tk1  [MAX_INFLIGHT];
    logic        meta_tk2  [MAX_INFLIGHT];
    logic [31:0] meta_tg1  [MAX_INFLIGHT];
    logic [31:0] meta_tg2  [MAX_INFLIGHT];

    logic [1:0]  grp_size;
    logic [31:0] next_pc;
    logic        push;
    logic        pop;
    logic        live_resp;
    logic        adef_fire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign icache_addr = pc;
    assign bp_pc       = pc;

    // Group size and predicted successor PC for the group starting at pc.
    always_comb begin
        grp_size = (pc[2] || bp_taken1) ? 2'd1 : 2'd2;
        if (bp_taken1) begin
            next_pc = bp_target1;
        end else if (grp_size == 2'd2 && bp_taken2) begin
            next_pc = bp_target2;
        end else begin
            next_pc = pc + ((grp_size == 2'd2) ? 32'd8 : 32'd4);
        end
    end

    // Request/response bookkeeping; a pop is only meaningful when something is outstanding.
    always_comb begin
        push         = icache_req && icache_addr_ok;
        pop          = icache_data_ok && !reset && (inflight != '0);
        live_resp    = pop && (cancel_cnt == '0) && !flush;
        inflight_nxt = inflight + CNT_W'(push) - CNT_W'(pop);
    end

    // FSM next state, request enable and delivery outputs.
    always_comb begin
        state_nxt           = state;
        icache_req          = 1'b0;
        adef_fire           = 1'b0;
        out_size            = 2'd0;
        out_pc1             = meta_pc[rd_ptr];
        out_inst1           = icache_rdata[31:0];
        out_pred_taken1     = meta_tk1[rd_ptr];
        out_pred_target1    = meta_tg1[rd_ptr];
        out_have_exception1 = 1'b0;
        out_exception_type1 = 6'h00;
        out_pc2             = meta_pc[rd_ptr] + 32'd4;
        out_inst2           = icache_rdata[63:32];
        out_pred_taken2     = meta_tk2[rd_ptr];
        out_pred_target2    = meta_tg2[rd_ptr];

        if (!reset && !flush && state == ST_RUN) begin
            icache_req = (pc[1:0] == 2'b00) && ibuf_ready && (inflight < MAX_CNT);
            // Fault only after every live response ahead of it has been delivered.
            adef_fire  = (pc[1:0] != 2'b00) && ibuf_ready && (inflight == cancel_cnt);
        end

        if (flush) begin
            state_nxt = ST_RUN;
        end else if (adef_fire) begin
            state_nxt = ST_STALL;
        end

        if (live_resp) begin
            out_size = meta_size[rd_ptr];
        end else if (adef_fire) begin
            out_size            = 2'd1;
            out_pc1             = pc;
            out_inst1           = 32'h0;
            out_have_exception1 = 1'b1;
            out_exception_type1 = EXC_ADEF;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // PC, outstanding-request counters and FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            inflight   <= '0;
            cancel_cnt <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (flush) begin
                pc         <= flush_target;
                cancel_cnt <= inflight_nxt;
            end else begin
                if (push) begin
                    pc <= next_pc;
                end
                if (pop && cancel_cnt != '0) begin
                    cancel_cnt <= cancel_cnt - 1'b1;
                end
            end
        end
    end

    // Metadata FIFO storage; contents are only read while an entry is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            meta_pc[wr_ptr]   <= pc;
            meta_size[wr_ptr] <= grp_size;
            meta_tk1[wr_ptr]  <= bp_taken1;
            meta_tk2[wr_ptr]  <= bp_taken2;
            meta_tg1[wr_ptr]  <= bp_target1;
            meta_tg2[wr_ptr]  <= bp_target2;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, all
// checked each cycle against a queue-based model of the fetch rules.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam int          MAX_INF  = 2;
    localparam logic [5:0]  EXC_ADEF = 6'h08;

    logic        clk = 1'b0;
    logic        reset, flush, icache_addr_ok, icache_data_ok, ibuf_ready;
    logic        bp_taken1, bp_taken2;
    logic [31:0] flush_target, bp_target1, bp_target2;
    logic [63:0] icache_rdata;
    logic        icache_req, out_pred_taken1, out_have_exception1, out_pred_taken2;
    logic [31:0] icache_addr, bp_pc, out_pc1, out_inst1, out_pred_target1;
    logic [31:0] out_pc2, out_inst2, out_pred_target2;
    logic [1:0]  out_size;
    logic [5:0]  out_exception_type1;

    fetch_unit #(.RESET_PC(RESET_PC), .MAX_INFLIGHT(MAX_INF)) dut (
        .clk(clk), .reset(reset), .flush(flush), .flush_target(flush_target),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_addr_ok(icache_addr_ok), .icache_data_ok(icache_data_ok),
        .icache_rdata(icache_rdata), .bp_pc(bp_pc),
        .bp_taken1(bp_taken1), .bp_target1(bp_target1),
        .bp_taken2(bp_taken2), .bp_target2(bp_target2),
        .ibuf_ready(ibuf_ready), .out_size(out_size),
        .out_pc1(out_pc1), .out_inst1(out_inst1),
        .out_pred_taken1(out_pred_taken1), .out_pred_target1(out_pred_target1),
        .out_have_exception1(out_have_exception1),
        .out_exception_type1(out_exception_type1),
        .out_pc2(out_pc2), .out_inst2(out_inst2),
        .out_pred_taken2(out_pred_taken2), .out_pred_target2(out_pred_target2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          size;
        logic        tk1, tk2;
        logic [31:0] tg1, tg2;
        bit          live;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_stall;
    int          total = 0;
    int          bad   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h5a5a0f0f;
    endfunction

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic a_rst, input logic a_fl, input logic [31:0] a_ft,
                        input logic a_aok, input logic a_dok, input logic a_rdy,
                        input logic a_t1, input logic [31:0] a_g1,
                        input logic a_t2, input logic [31:0] a_g2);
        bit   m_req, live_any, deliver, adef;
        int   sz, exp_size;
        logic [31:0] nxt;
        ent_t e;
        @(negedge clk);
        a_dok = a_dok && !a_rst && (q.size() > 0);
        reset = a_rst; flush = a_fl; flush_target = a_ft;
        icache_addr_ok = a_aok; icache_data_ok = a_dok; ibuf_ready = a_rdy;
        bp_taken1 = a_t1; bp_target1 = a_g1; bp_taken2 = a_t2; bp_target2 = a_g2;
        if (a_dok) icache_rdata = {mem_word(q[0].pc + 32'd4), mem_word(q[0].pc)};
        else       icache_rdata = {$urandom, $urandom};
        #1;
        live_any = 0;
        foreach (q[i]) if (q[i].live) live_any = 1;
        m_req   = !a_rst && !a_fl && !m_stall && m_pc[1:0] == 2'b00 && a_rdy && q.size() < MAX_INF;
        adef    = !a_rst && !a_fl && !m_stall && m_pc[1:0] != 2'b00 && a_rdy && !live_any;
        deliver = a_dok && !a_fl && q[0].live;
        sz      = (m_pc[2] || a_t1) ? 1 : 2;
        if (a_t1)                nxt = a_g1;
        else if (sz == 2 && a_t2) nxt = a_g2;
        else                     nxt = m_pc + 32'(4 * sz);
        exp_size = deliver ? q[0].size : (adef ? 1 : 0);

        chk_eq("icache_req", icache_req, m_req);
        if (m_req) begin
            chk_eq("icache_addr", icache_addr, m_pc);
            chk_eq("bp_pc", bp_pc, m_pc);
        end
        chk_eq("out_size", out_size, exp_size);
        if (deliver) begin
            chk_eq("pc1", out_pc1, q[0].pc);
            chk_eq("inst1", out_inst1, mem_word(q[0].pc));
            chk_eq("pred_taken1", out_pred_taken1, q[0].tk1);
            chk_eq("pred_target1", out_pred_target1, q[0].tg1);
            chk_eq("have_exc1", out_have_exception1, 1'b0);
            if (q[0].size == 2) begin
                chk_eq("pc2", out_pc2, q[0].pc + 32'd4);
                chk_eq("inst2", out_inst2, mem_word(q[0].pc + 32'd4));
                chk_eq("pred_taken2", out_pred_taken2, q[0].tk2);
                chk_eq("pred_target2", out_pred_target2, q[0].tg2);
            end
        end
        if (adef) begin
            chk_eq("adef_pc1", out_pc1, m_pc);
            chk_eq("adef_inst1", out_inst1, 32'h0);
            chk_eq("adef_have_exc", out_have_exception1, 1'b1);
            chk_eq("adef_type", out_exception_type1, EXC_ADEF);
        end

        if (a_rst) begin
            m_pc = RESET_PC; q.delete(); m_stall = 0;
        end else begin
            if (a_dok) void'(q.pop_front());
            if (a_fl) begin
                foreach (q[i]) q[i].live = 0;
                m_pc = a_ft; m_stall = 0;
            end else begin
                if (m_req && a_aok) begin
                    e.pc = m_pc; e.size = sz; e.tk1 = a_t1; e.tk2 = a_t2;
                    e.tg1 = a_g1; e.tg2 = a_g2; e.live = 1;
                    q.push_back(e);
                    m_pc = nxt;
                end
                if (adef) m_stall = 1;
            end
        end
    endtask

    task automatic idle(input logic a_aok, input logic a_dok, input logic a_rdy);
        step(0, 0, 32'h0, a_aok, a_dok, a_rdy, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic redirect(input logic [31:0] tgt, input logic a_dok);
        step(0, 1, tgt, 1, a_dok, 1, 0, 32'h0, 0, 32'h0);
    endtask

    function automatic logic [31:0] rnd_target(input int misalign_odds);
        logic [31:0] t;
        t = 32'h1c000000 | ({16'h0, 16'($urandom)} & 32'h0000fffc);
        if ($urandom_range(misalign_odds - 1) == 0) t[1] = 1'b1;
        return t;
    endfunction

    initial begin
        reset = 1; flush = 0; flush_target = 0; icache_addr_ok = 0; icache_data_ok = 0;
        ibuf_ready = 0; bp_taken1 = 0; bp_taken2 = 0; bp_target1 = 0; bp_target2 = 0;
        icache_rdata = 0; m_pc = RESET_PC; m_stall = 0;

        // reset cycles, then straight-line fetch with data one cycle after accept
        step(1, 1, 32'h1c000400, 1, 1, 1, 0, 32'h0, 0, 32'h0);
        step(1, 0, 32'h0, 1, 0, 1, 0, 32'h0, 0, 32'h0);
        repeat (4) idle(1, 1, 1);

        // odd-word redirect gives a single-instruction group
        redirect(32'h1c000104, 1);
        repeat (4) idle(1, 1, 1);

        // taken prediction in slot 1
        redirect(32'h1c000000, 1);
        step(0, 0, 32'h0, 1, 1, 1, 1, 32'h1c000200, 0, 32'h0);
        repeat (3) idle(1, 1, 1);

        // taken prediction in slot 2
        step(0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 1, 32'h1c000340);
        repeat (3) idle(1, 1, 1);

        // flush with two requests outstanding
        redirect(32'h1c000000, 1);
        repeat (3) idle(1, 1, 1);
        idle(1, 0, 1);
        idle(1, 0, 1);
        redirect(32'h1c000400, 0);
        repeat (5) idle(1, 1, 1);

        // misaligned redirect: one ADEF then silence
        redirect(32'h1c000002, 1);
        repeat (6) idle(1, 1, 1);
        redirect(32'h1c000010, 1);
        repeat (3) idle(1, 1, 1);

        // instruction buffer backpressure
        repeat (5) idle(1, 1, 0);
        repeat (4) idle(1, 1, 1);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            logic r, f, t1, t2;
            r  = ($urandom_range(299) == 0);
            f  = ($urandom_range(24) == 0);
            t1 = ($urandom_range(3) == 0);
            t2 = ($urandom_range(3) == 0);
            step(r, f, rnd_target(8), $urandom_range(9) < 7, $urandom_range(9) < 6,
                 $urandom_range(19) < 17, t1, rnd_target(40), t2, rnd_target(40));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c000000, PC loaded on reset.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 2, maximum outstanding icache requests.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  in  1  redirect fetch to flush_target; cancel everything in flight.
REQ-006 SHALL have port flush_target  in  32  redirect PC.
REQ-007 SHALL have port icache_req  out  1  request valid.
REQ-008 SHALL have port icache_addr  out  32  request PC (word aligned).
REQ-009 SHALL have port icache_addr_ok  in  1  request accepted this cycle.
REQ-010 SHALL have port icache_data_ok  in  1  oldest accepted request returns data this cycle.
REQ-011 SHALL have port icache_rdata  in  64  [31:0]=inst at request PC, [63:32]=inst at PC+4.
REQ-012 SHALL have port bp_pc  out  32  equals icache_addr; predictor lookup PC.
REQ-013 SHALL have ports bp_taken1/bp_taken2 (in, 1) and bp_target1/bp_target2 (in, 32)  combinational predictions for bp_pc and bp_pc+4.
REQ-014 SHALL have port ibuf_ready  in  1  buffer can absorb two more instructions.
REQ-015 SHALL have port out_size  out  2  instructions delivered this cycle (0/1/2).
REQ-016 SHALL have ports out_pc1/out_inst1/out_pred_taken1/out_pred_target1/out_have_exception1/out_exception_type1 (exception_t), and out_pc2/out_inst2/out_pred_taken2/out_pred_target2  out  slot data to the instruction buffer.

Function
REQ-017 Fetch group size SHALL be 1 when pc[2]=1, else 2; if size 2 and bp_taken1=1, size SHALL be reduced to 1.
REQ-018 Next PC SHALL be bp_target1 if slot 1 predicted taken, else bp_target2 if size 2 and bp_taken2, else pc+4*size (32-bit wrap).
REQ-019 icache_req SHALL assert when not in reset, no flush this cycle, pc[1:0]=0, ibuf_ready=1, inflight<MAX_INFLIGHT, state RUN.
REQ-020 On icache_req&&icache_addr_ok: PC SHALL advance to next PC; {pc, size, taken1/2, target1/2} SHALL be pushed into a MAX_INFLIGHT-deep in-order metadata FIFO; inflight increments.
REQ-021 On icache_data_ok with cancel_cnt=0: out_size SHALL equal FIFO-head size in the same cycle, slot data from icache_rdata and FIFO head; FIFO pops; inflight decrements.
REQ-022 On icache_data_ok with cancel_cnt>0: out_size SHALL be 0, cancel_cnt and inflight decrement, FIFO pops.
REQ-023 Simultaneous addr_ok and data_ok SHALL leave inflight unchanged and FIFO push/pop both take effect.
REQ-024 Flush SHALL set PC=flush_target, cancel_cnt=inflight after this cycle's addr_ok/data_ok accounting, out_size=0 this cycle, state RUN.
REQ-025 Flush in a data_ok cycle SHALL discard that response; flush with addr_ok the same cycle SHALL not occur since icache_req=0 under flush.
REQ-026 If pc[1:0]!=0 in RUN: no request; once inflight=cancel_cnt (all live responses delivered) and ibuf_ready=1, SHALL emit out_size=1, out_pc1=pc, out_inst1=0, out_have_exception1=1, out_exception_type1=ADEF, then enter STALL.
REQ-027 STALL SHALL issue no requests and deliver nothing until flush.
REQ-028 Slot 2 SHALL never carry an exception; out_have_exception1=0 for normal deliveries.
REQ-029 Outputs when out_size=0 SHALL be don't-care except out_size itself.

Reset
REQ-030 Reset SHALL take priority over flush: PC=RESET_PC, inflight=0, cancel_cnt=0, FIFO empty, state RUN.
REQ-031 During the reset cycle icache_req=0 and out_size=0; responses arriving in that cycle SHALL be ignored.
REQ-032 Environment SHALL guarantee no icache_data_ok after reset for pre-reset requests.

Verification
REQ-033 Reset, pc=0x1c000000, bp all 0, addr_ok=1, data_ok one cycle later -> addresses 0x1c000000, 0x1c000008; out_size=2 each.
REQ-034 flush_target=0x1c000104 -> request size 1, next request 0x1c000108.
REQ-035 pc=0x1c000000, bp_taken1=1, bp_target1=0x1c000200 -> out_size=1, out_pred_taken1=1, next addr 0x1c000200.
REQ-036 Two requests in flight, flush to 0x1c000400 -> next two data_ok give out_size=0, then first delivery pc=0x1c000400.
REQ-037 flush_target=0x1c000002 -> no icache_req, one out_size=1 with ADEF, then silent until next flush.
REQ-038 ibuf_ready=0 for 5 cycles -> icache_req=0, PC held; resumes unchanged when ready returns.
